// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC frame controller: state encoding,
// default generator/seed and the width of the reported frame length.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int         FRAME_LEN_W = 16;
    localparam logic [3:0] DEF_POLY    = 4'h3;
    localparam logic [3:0] DEF_INIT    = 4'h0;

endpackage

// File: rtl/crc_serial_core.sv
// Bit-serial Galois CRC register, MSB-first. The frame controller decides
// when to clear (load INIT) and when to advance by one input bit.
module crc_serial_core
    import crc_pkg::*;
#(
    parameter int               CRC_W = 4,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(DEF_POLY),
    parameter logic [CRC_W-1:0] INIT  = CRC_W'(DEF_INIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_q
);

    logic             fb;
    logic [CRC_W-1:0] crc_next;

    assign fb       = crc_q[CRC_W-1] ^ bit_in;
    assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (POLY & {CRC_W{fb}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= INIT;
        end else if (clr) begin
            crc_q <= INIT;
        end else if (en) begin
            crc_q <= crc_next;
        end
    end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer: accepts bytes, shifts them MSB-first into crc_serial_core and
// reports CRC + byte count per frame. Optional CRC_CHECK_EN adds chk_value/crc_err.
module crc_frame_ctrl
    import crc_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 4,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(DEF_POLY),
    parameter logic [CRC_W-1:0] INIT   = CRC_W'(DEF_INIT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_last,
`ifdef CRC_CHECK_EN
    input  logic [CRC_W-1:0]       chk_value,
    output logic                   crc_err,
`endif
    output logic                   busy,
    output logic                   crc_valid,
    output logic [CRC_W-1:0]       crc_value,
    output logic [FRAME_LEN_W-1:0] frame_len
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t                 state;
    logic [DATA_W-1:0]      shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   last_q;
    logic                   sof;
    logic                   res_hold;
    logic [FRAME_LEN_W-1:0] byte_cnt;
    logic                   accept;
    logic [CRC_W-1:0]       crc_q;

    assign accept = s_valid & s_ready;

    crc_serial_core #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept & sof),
        .en     (state == ST_SHIFT),
        .bit_in (shreg[DATA_W-1]),
        .crc_q  (crc_q)
    );

    // The core is idle from the last shift until the next start-of-frame clear,
    // so its register already holds the result; res_hold gates it onto crc_value.
    assign crc_value = res_hold ? crc_q : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= s_data;
        end else if (state == ST_SHIFT) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            crc_valid <= 1'b0;
            frame_len <= '0;
            bit_cnt   <= '0;
            last_q    <= 1'b0;
            sof       <= 1'b1;
            res_hold  <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    crc_valid <= 1'b0;
                    if (accept) begin
                        last_q  <= s_last;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                        if (sof) begin
                            byte_cnt <= FRAME_LEN_W'(1);
                            sof      <= 1'b0;
                            res_hold <= 1'b0;
                        end else if (byte_cnt != '1) begin
                            byte_cnt <= byte_cnt + FRAME_LEN_W'(1);
                        end
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == '0) begin
                        if (last_q) begin
                            state     <= ST_DONE;
                            crc_valid <= 1'b1;
                            res_hold  <= 1'b1;
                            frame_len <= byte_cnt;
                        end else begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    crc_valid <= 1'b0;
                    sof       <= 1'b1;
                    busy      <= 1'b0;
                    s_ready   <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CRC_CHECK_EN
    logic [CRC_W-1:0] chk_q;

    always_ff @(posedge clk) begin
        if (accept && s_last) begin
            chk_q <= chk_value;
        end
    end

    assign crc_err = res_hold & (crc_q != chk_q);
`endif

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Self-checking bench for crc_frame_ctrl: polynomial long-division reference model,
// per-cycle output comparison and directed frames (CRC_CHECK_EN adds the check test).
module tb_crc_frame_ctrl;

    localparam logic [4:0] GEN = 5'b10011;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int          due;
        logic [3:0]  crc;
        logic [15:0] len;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        busy;
    logic        crc_valid;
    logic [3:0]  crc_value;
    logic [15:0] frame_len;
`ifdef CRC_CHECK_EN
    logic [3:0]  chk_value;
    logic        crc_err;
`endif

    crc_frame_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
`ifdef CRC_CHECK_EN
        .chk_value (chk_value),
        .crc_err   (crc_err),
`endif
        .busy      (busy),
        .crc_valid (crc_valid),
        .crc_value (crc_value),
        .frame_len (frame_len)
    );

    always #5 clk = ~clk;

    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    int      hs_cyc   = 0;
    int      ready_from = 1;
    bit      have_acc = 0;
    bit      sof_m    = 1;
    logic       exp_valid = 0;
    logic [3:0] exp_val   = 0;
    logic [15:0] exp_len  = 0;
    logic       exp_err   = 0;
    byte_q_t frame_bytes;
    res_t    results[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Remainder of M(x)*x^4 divided by x^4+x+1 (INIT=0).
    function automatic logic [3:0] model_crc(input byte_q_t msg);
        bit bits[$];
        foreach (msg[i])
            for (int b = 7; b >= 0; b--) bits.push_back(msg[i][b]);
        repeat (4) bits.push_back(1'b0);
        for (int i = 0; i < bits.size() - 4; i++)
            if (bits[i])
                for (int j = 0; j < 5; j++) bits[i+j] = bits[i+j] ^ GEN[4-j];
        return {bits[bits.size()-4], bits[bits.size()-3], bits[bits.size()-2], bits[bits.size()-1]};
    endfunction

    // Model update at every rising edge.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            ready_from = cyc + 1;
            have_acc   = 0;
            sof_m      = 1;
            exp_valid  = 0;
            exp_val    = 0;
            exp_len    = 0;
            exp_err    = 0;
            frame_bytes.delete();
            results.delete();
        end else begin
            exp_valid = 0;
            if (results.size() > 0 && results[0].due == cyc) begin
                exp_valid = 1;
                exp_val   = results[0].crc;
                exp_len   = results[0].len;
                exp_err   = results[0].err;
                void'(results.pop_front());
            end
            if (s_valid && s_ready) begin
                res_t r;
                if (sof_m) begin
                    frame_bytes.delete();
                    sof_m   = 0;
                    exp_val = 0;
                    exp_err = 0;
                end
                frame_bytes.push_back(s_data);
                have_acc = 1;
                if (s_last) begin
                    r.due = cyc + 8;
                    r.crc = model_crc(frame_bytes);
                    r.len = (frame_bytes.size() > 65535) ? 16'hFFFF : 16'(frame_bytes.size());
                    r.err = 1'b0;
`ifdef CRC_CHECK_EN
                    r.err = (r.crc != chk_value);
`endif
                    results.push_back(r);
                    sof_m      = 1;
                    ready_from = cyc + 9;
                end else begin
                    ready_from = cyc + 8;
                end
            end
        end
    end

    // Output comparison at every falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_s_ready", s_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_crc_valid", crc_valid, 0);
            check("rst_crc_value", crc_value, 0);
            check("rst_frame_len", frame_len, 0);
        end else begin
            check("s_ready", s_ready, cyc >= ready_from);
            check("busy", busy, have_acc && (cyc < ready_from));
            check("crc_valid", crc_valid, exp_valid);
            check("crc_value", crc_value, exp_val);
            check("frame_len", frame_len, exp_len);
`ifdef CRC_CHECK_EN
            check("crc_err", crc_err, exp_err);
`endif
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("handshake_timeout", 0, 1);
            s_valid = 1'b0;
        end else begin
            hs_cyc = cyc;
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        while (!crc_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, cyc - hs_cyc, 9);
    endtask

    initial begin
        byte_q_t q;
        int      hs1;
        int      seen;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
`ifdef CRC_CHECK_EN
        chk_value = 4'h0;
`endif
        q = {8'hB2};
        check("model_b2", model_crc(q), 4'h7);
        q = {8'hB2, 8'h00};
        check("model_b2_00", model_crc(q), 4'h8);

        // Reset release: s_ready rises one edge later
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_ready_low", s_ready, 0);
        @(negedge clk);
        check("release_ready_high", s_ready, 1);

        // 1-byte frame
        send_byte(8'hB2, 1'b1);
        idle();
        wait_result("latency_1byte");
        check("f1_crc", crc_value, 4'h7);
        check("f1_len", frame_len, 1);
        repeat (4) @(negedge clk);
        check("f1_crc_held", crc_value, 4'h7);

        // 2-byte frame with s_valid held through SHIFT
        send_byte(8'hB2, 1'b0);
        hs1 = hs_cyc;
        send_byte(8'h00, 1'b1);
        check("byte_period", hs_cyc - hs1, 9);
        idle();
        wait_result("latency_2byte");
        check("f2_crc", crc_value, 4'h8);
        check("f2_len", frame_len, 2);

        // Back-to-back single-byte frames
        send_byte(8'hB2, 1'b1);
        idle();
        wait_result("latency_b2b_a");
        check("b2b_a_crc", crc_value, 4'h7);
        send_byte(8'hB2, 1'b1);
        check("b2b_hold_at_accept", crc_value, 4'h7);
        idle();
        check("b2b_sof_clear", crc_value, 4'h0);
        wait_result("latency_b2b_b");
        check("b2b_b_crc", crc_value, 4'h7);
        check("b2b_b_len", frame_len, 1);

        // Reset during SHIFT of the second byte
        send_byte(8'hB2, 1'b0);
        send_byte(8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", s_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", crc_valid, 0);
        check("async_rst_value", crc_value, 0);
        check("async_rst_len", frame_len, 0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (crc_valid) seen++;
        end
        check("no_valid_after_rst", seen, 0);
        send_byte(8'hB2, 1'b1);
        idle();
        wait_result("latency_after_rst");
        check("after_rst_crc", crc_value, 4'h7);
        check("after_rst_len", frame_len, 1);

`ifdef CRC_CHECK_EN
        chk_value = 4'h7;
        send_byte(8'hB2, 1'b1);
        idle();
        wait_result("latency_chk_ok");
        check("chk_match_err", crc_err, 0);
        chk_value = 4'h5;
        send_byte(8'hB2, 1'b1);
        idle();
        wait_result("latency_chk_bad");
        check("chk_mismatch_err", crc_err, 1);
`endif

        repeat (5) @(negedge clk);
        check("pending_results", results.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
